// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM state codes,
// instruction opcodes and PC source selects.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JUMP   = 2'd2
  } pc_src_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running count of retired instructions; wraps modulo 2^CNTW.
module retire_counter #(
  parameter int CNTW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  output logic [CNTW-1:0] count
);

  logic [CNTW-1:0] count_r;

  // Count register: reset has priority over a same-cycle completion
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CNTW{1'b0}};
    end else if (en) begin
      count_r <= count_r + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: walks each instruction through
// fetch/decode/execute/memory/write-back and drives datapath enables.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNTW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            ir_load,
  output logic            a_load,
  output logic            b_load,
  output logic            aluout_load,
  output logic            mdr_load,
  output logic            pc_load,
  output logic [1:0]      pc_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            rf_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [2:0]      state,
  output logic [CNTW-1:0] retired
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [5:0] op_r;
  logic       done_r;
  logic       complete_s;
  pc_src_t    pc_src_s;

  // State, latched opcode and completion pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      op_r    <= 6'h00;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= complete_s;
      if (state_r == ST_DECODE) begin
        op_r <= opcode;
      end else begin
        op_r <= op_r;
      end
    end
  end

  // Next-state and output decode; only mem_ready and zero qualify outputs
  always_comb begin
    state_nxt_s = state_r;
    complete_s  = 1'b0;
    ir_load     = 1'b0;
    a_load      = 1'b0;
    b_load      = 1'b0;
    aluout_load = 1'b0;
    mdr_load    = 1'b0;
    pc_load     = 1'b0;
    pc_src_s    = PC_SRC_ALU;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    rf_write    = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    illegal     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_load     = 1'b1;
          pc_load     = 1'b1;
          pc_src_s    = PC_SRC_ALU;
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        a_load      = 1'b1;
        b_load      = 1'b1;
        aluout_load = 1'b1;
        if (op_is_legal(opcode)) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_TRAP;
        end
      end
      ST_EXEC: begin
        case (op_r)
          OP_R: begin
            aluout_load = 1'b1;
            state_nxt_s = ST_WB;
          end
          OP_LW, OP_SW: begin
            aluout_load = 1'b1;
            state_nxt_s = ST_MEM;
          end
          OP_BEQ: begin
            pc_src_s    = PC_SRC_ALUOUT;
            pc_load     = zero;
            state_nxt_s = ST_IDLE;
            complete_s  = 1'b1;
          end
          OP_J: begin
            pc_src_s    = PC_SRC_JUMP;
            pc_load     = 1'b1;
            state_nxt_s = ST_IDLE;
            complete_s  = 1'b1;
          end
          default: begin
            state_nxt_s = ST_TRAP;
          end
        endcase
      end
      ST_MEM: begin
        // Strobes stay asserted for every cycle the memory stalls
        if (op_r == OP_SW) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            state_nxt_s = ST_IDLE;
            complete_s  = 1'b1;
          end else begin
            state_nxt_s = ST_MEM;
          end
        end else begin
          mem_read = 1'b1;
          if (mem_ready) begin
            mdr_load    = 1'b1;
            state_nxt_s = ST_WB;
          end else begin
            state_nxt_s = ST_MEM;
          end
        end
      end
      ST_WB: begin
        rf_write    = 1'b1;
        mem_to_reg  = (op_r == OP_LW);
        reg_dst     = (op_r == OP_R);
        state_nxt_s = ST_IDLE;
        complete_s  = 1'b1;
      end
      ST_TRAP: begin
        illegal     = 1'b1;
        state_nxt_s = ST_TRAP;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  retire_counter #(.CNTW(CNTW)) u_retire_counter (
    .clock (clock),
    .reset (reset),
    .en    (complete_s),
    .count (retired)
  );

  assign pc_src = pc_src_s;
  assign state  = state_r;
  assign busy   = (state_r != ST_IDLE);
  assign done   = done_r;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control sequencer for the CPU datapath. It steps each instruction through fetch, decode, execute, memory and write-back. At each step it drives the load enables of the datapath registers (IR, operand registers A/B, ALUOut, MDR, PC), the memory strobes and the register-file write. It sits beside the datapath, takes the IR opcode and the ALU zero flag as inputs, and handshakes with the memory interface through `mem_ready`.

## Interface
- `CNTW`, 32, width of the retired-instruction counter

- `clock`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request to begin the next instruction; sampled in IDLE only
- `opcode`  in  6  IR[31:26]; valid from DECODE onward
- `zero`  in  1  ALU zero flag; valid in EXEC
- `mem_ready`  in  1  memory completed current read/write this cycle
- `ir_load`, `a_load`, `b_load`, `aluout_load`, `mdr_load`, `pc_load`  out  1 each  datapath register load enables
- `pc_src`  out  2  0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = jump target
- `mem_read`, `mem_write`  out  1 each  memory strobes
- `rf_write`  out  1  register-file write enable
- `mem_to_reg`  out  1  write-back data select: 1 = MDR, 0 = ALUOut
- `reg_dst`  out  1  write register select: 1 = rd, 0 = rt
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle completion pulse (registered)
- `illegal`  out  1  high while in TRAP
- `state`  out  3  current state code, for debug
- `retired`  out  CNTW  count of completed instructions

## Operation
- Opcodes:
  - R = 6'h00
  - LW = 6'h23
  - SW = 6'h2B
  - BEQ = 6'h04
  - J = 6'h02
  - all others are illegal.
- State codes: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6.
- Output decode:
  - Outputs not listed for a state are 0.
  - All outputs are decoded from the state register, except those qualified by `mem_ready` or `zero` below.
- IDLE:
  - `start` = 1 moves to FETCH.
- FETCH:
  - `mem_read` = 1.
  - When `mem_ready` = 1: `ir_load` = 1, `pc_load` = 1, `pc_src` = 0, then move to DECODE.
  - Otherwise hold in FETCH.
- DECODE:
  - `a_load` = `b_load` = `aluout_load` = 1 (branch target computed).
  - Legal opcode moves to EXEC; illegal opcode moves to TRAP.
- EXEC, by opcode:
  - R / LW / SW: `aluout_load` = 1. R goes to WB; LW and SW go to MEM.
  - BEQ: `pc_src` = 1, `pc_load` = `zero`, then IDLE (completes).
  - J: `pc_src` = 2, `pc_load` = 1, then IDLE (completes).
- MEM:
  - LW: `mem_read` = 1. On `mem_ready`: `mdr_load` = 1, move to WB.
  - SW: `mem_write` = 1. On `mem_ready`: move to IDLE (completes).
  - Without `mem_ready`, hold with strobes asserted.
- WB:
  - `rf_write` = 1.
  - `mem_to_reg` = 1 for LW.
  - `reg_dst` = 1 for R.
  - Move to IDLE (completes).
- TRAP:
  - `illegal` = 1.
  - `start` is ignored; only `reset` leaves TRAP.
- Completion:
  - The transition into IDLE from EXEC, MEM or WB sets `done` for exactly the following cycle.
  - The same transition increments `retired` by 1 (modulo 2^CNTW).
- `opcode` is latched internally at DECODE. Later changes on the `opcode` input do not affect the current instruction.

## Timing
- Reset (synchronous): next edge gives state = IDLE, `retired` = 0, `done` = 0; all other outputs follow IDLE decode (all 0).
- Reset mid-instruction: aborts without `done` and without incrementing `retired`. Any partially asserted strobe drops the cycle after the reset edge.
- Cycle count from the `start` edge to `done` high, with `mem_ready` always 1:
  - R: 5
  - LW: 6
  - SW: 5
  - BEQ: 4
  - J: 4
- Each cycle of `mem_ready` = 0 in FETCH or MEM adds one cycle.
- Back-to-back: `start` high in the `done` cycle is accepted, and FETCH begins on the next edge.
- `reset` and `start` in the same cycle: reset wins.
- `retired` at all-ones wraps to 0 on the next completion.
- `zero` is sampled only in EXEC for BEQ.
- `mem_ready` is ignored outside FETCH and MEM.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - state enum/codes
  - opcode constants
  - `pc_src` encodings
- Datapath decode units import the same opcode constants from `cpu_ctrl_pkg`.
- Sub-module `retire_counter`: CNTW-wide counter with enable and synchronous reset.
- The FSM and output decode stay in `multicycle_ctrl`.

## Test plan
- R-type (`opcode` = 0x00), `mem_ready` tied 1, start pulse:
  - state sequence 1, 2, 3, 5, 0
  - `rf_write` and `reg_dst` high in WB only
  - `done` one cycle, 5 cycles after `start`
  - `retired` = 1
- LW with `mem_ready` low for 3 cycles in MEM:
  - `mem_read` held 4 cycles in MEM
  - `mdr_load` is a single pulse
  - `mem_to_reg` = 1 in WB
  - `done` at cycle 9
- BEQ with `zero` = 0, then with `zero` = 1:
  - `pc_load` = 0 in EXEC, then `pc_load` = 1 with `pc_src` = 1
  - both finish in 4 cycles
- Illegal `opcode` 0x3F:
  - TRAP reached after DECODE, `illegal` = 1
  - subsequent `start` pulses ignored
  - reset returns to IDLE with `retired` unchanged at 0
- Reset asserted in MEM of SW:
  - next cycle: state = 0, `mem_write` = 0, no `done`
  - following back-to-back J instructions with `start` held high complete every 4 cycles
- With `retired` preloaded to 2^CNTW−1 (or CNTW = 4 with 15 instructions run), one more completion gives `retired` = 0.
